fifo_ptr_ctrl: RTL
==================

Name: fifo_ptr_ctrl

Overview:
Parametrised pointer/occupancy controller for single-clock synchronous FIFOs. It generalises the 3-bit up/down occupancy counter to any depth, including non-power-of-two depths. It gates write/read requests against full/empty and generates wrapping read/write addresses for an external RAM. It also provides full/empty/almost flags, sticky overflow/underflow errors and a high-watermark register.

Parameters:
DEPTH, 8, number of FIFO entries; any integer >= 2, power of two not required
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
AW (derived localparam), clog2(DEPTH), pointer width
CW (derived localparam), clog2(DEPTH+1), count width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_req  in  1  producer requests a write this cycle
rd_req  in  1  consumer requests a read this cycle
clr_err  in  1  clears overflow/underflow
clr_peak  in  1  reloads peak with the next count
wr_en  out  1  write accepted this cycle (RAM write strobe), combinational
rd_en  out  1  read accepted this cycle, combinational
wr_ptr  out  AW  RAM write address, registered
rd_ptr  out  AW  RAM read address, registered
count  out  CW  current occupancy, registered
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
overflow  out  1  sticky: a write was refused
underflow  out  1  sticky: a read was refused
peak  out  CW  maximum count since reset or clr_peak

Behaviour:
- Reset (synchronous, highest priority):
  - wr_ptr, rd_ptr, count, peak, overflow and underflow go to 0.
  - Therefore empty=1, almost_empty=1, full=0, almost_full=0.
  - While reset=1, wr_en=rd_en=0 regardless of requests.
  - Reset mid-operation discards all in-flight occupancy; no error is flagged for requests during reset.
- Acceptance (combinational from registered state):
  - rd_en = rd_req & ~empty
  - wr_en = wr_req & (~full | rd_req)
  - When full with both requests: both are accepted and count holds.
  - When empty with both requests: only the write is accepted (no fall-through), and count increments.
- Pointers:
  - Each pointer advances by 1 on its enable.
  - Wraps from DEPTH-1 to 0 (explicit compare, not natural binary overflow).
- Count:
  - +1 on wr_en & ~rd_en.
  - -1 on rd_en & ~wr_en.
  - Holds otherwise.
  - Never exceeds DEPTH and never goes below 0.
  - Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, with count==DEPTH when the pointers are equal and the FIFO is full.
- Flags:
  - Decoded combinationally from the registered count.
  - Valid in the same cycle count changes; no extra latency.
- Errors:
  - overflow sets on wr_req & ~wr_en; underflow sets on rd_req & ~rd_en.
  - Both are sticky until clr_err.
  - If clr_err and a new refusal occur in the same cycle, set wins.
- Peak:
  - Each cycle, peak <= max(peak, count_next).
  - clr_peak loads count_next.
- Latency: a request accepted in cycle N is reflected in count/pointers/flags from cycle N+1.

Test Plan:
- DEPTH=5, AF=4, AE=1: reset, 5 single writes -> count 1..5, wr_ptr 1,2,3,4,0, almost_full at count 4, full at 5, empty=0.
- Full, wr_req only -> wr_en=0, count stays 5, overflow=1; assert clr_err -> overflow=0 next cycle.
- Full, wr_req+rd_req together -> wr_en=rd_en=1, count stays 5, both pointers advance by 1 (wrap checked).
- Empty, wr_req+rd_req together -> rd_en=0, wr_en=1, count=1, underflow=1; rd_req alone on empty -> underflow stays set.
- Fill to 3, drain to 0, clr_peak, fill to 2 -> peak 3 before clr_peak, then 0, then 2; assert reset mid-fill -> all outputs 0, empty=1 next cycle.
- Random 2000-cycle wr_req/rd_req vs scoreboard model, DEPTH=8 and DEPTH=5 -> count/pointer invariant holds every cycle, no count > DEPTH or < 0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for a single-clock FIFO of arbitrary depth.
// Gates requests against full/empty, wraps RAM addresses, tracks flags, errors and peak.
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          clr_err,
  input  logic          clr_peak,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow,
  output logic [CW-1:0] peak
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [CW-1:0] peak_q,   peak_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          af_q,     af_d;
  logic          ae_q,     ae_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          wr_acc,   rd_acc;

  // Acceptance: a write into a full FIFO is allowed only alongside a read.
  always_comb begin
    rd_acc = rd_req & ~empty_q & ~reset;
    wr_acc = wr_req & (~full_q | rd_req) & ~reset;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // A refusal in the same cycle as clr_err keeps the error set.
    ovf_d = (ovf_q & ~clr_err) | (wr_req & ~wr_acc);
    udf_d = (udf_q & ~clr_err) | (rd_req & ~rd_acc);

    peak_d = (clr_peak || (count_d > peak_q)) ? count_d : peak_q;

    // Flags are registered from count_d so they line up with count.
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_LVL);
    ae_d    = (count_d <= AE_LVL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign wr_en        = wr_acc;
  assign rd_en        = rd_acc;
  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign peak         = peak_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
